core_mem_arbiter: RTL and testbench
===================================

// Module: core_mem_arbiter
// PURPOSE
// - Shares the single LETC core memory port between instruction fetch (IF) and load/store (LS).
// - core_control raises IF requests in FETCH and LS requests in LOAD_CYCLE_1 and similar states.
// - Arbitrates, registers the winning request, issues it on the memory port, then routes the
//   response back to its owner.
// - Exactly one transaction is outstanding at a time.
// PARAMETERS
// - AW  32  address width in bits
// - DW  32  data width in bits; must be a multiple of 8
// PORTS
// clk            input   1      core clock, all state on rising edge
// rst_n          input   1      asynchronous, active-low reset
// if_req_valid   input   1      IF requests a read
// if_req_addr    input   AW     IF read address
// if_req_ready   output  1      IF request accepted this cycle
// if_rsp_valid   output  1      IF response valid (one-cycle pulse)
// if_rsp_data    output  DW     IF read data
// if_rsp_err     output  1      IF access fault
// ls_req_valid   input   1      LS requests an access
// ls_req_addr    input   AW     LS address
// ls_req_wen     input   1      1 = store, 0 = load
// ls_req_wdata   input   DW     store data
// ls_req_wstrb   input   DW/8   store byte enables
// ls_req_ready   output  1      LS request accepted this cycle
// ls_rsp_valid   output  1      LS response valid (one-cycle pulse)
// ls_rsp_data    output  DW     LS load data
// ls_rsp_err     output  1      LS access fault
// mem_req_valid  output  1      memory request valid
// mem_req_ready  input   1      memory accepts request
// mem_req_addr   output  AW     memory address
// mem_req_wen    output  1      memory write enable
// mem_req_wdata  output  DW     memory write data
// mem_req_wstrb  output  DW/8   memory byte enables
// mem_rsp_valid  input   1      memory response valid
// mem_rsp_data   input   DW     memory read data
// mem_rsp_err    input   1      memory access fault
// proto_err      output  1      sticky: mem_rsp_valid seen outside WAIT
// BEHAVIOUR
// - Reset values: state=IDLE, last_grant=IF, every mem_req_* register=0, proto_err=0.
//   All *_ready and *_rsp_valid outputs read 0 during reset.
// - States and transitions:
//   - IDLE -> ISSUE on an accepted request.
//   - ISSUE -> WAIT on mem_req_valid && mem_req_ready.
//   - WAIT -> IDLE on mem_rsp_valid.
// - IDLE arbitration (combinational, from the valids):
//   - Only one requester valid: it wins.
//   - Both valid: the winner is the requester NOT equal to last_grant (round-robin).
//     Because last_grant resets to IF, LS wins the first tie.
//   - if_req_ready / ls_req_ready = (state==IDLE) && winner. Both are 0 outside IDLE.
// - On accept:
//   - Latch addr/wen/wdata/wstrb into the mem_req_* registers.
//   - For IF, wen=0, wstrb=0 and wdata=0.
//   - Set owner and update last_grant.
// - Handshake timing:
//   - mem_req_valid=1 exactly in ISSUE.
//   - mem_req_* payload is held stable until mem_req_ready is seen; no withdrawal.
// - Response routing (combinational pass-through, zero latency):
//   - x_rsp_valid = mem_rsp_valid && state==WAIT && owner==x.
//   - rsp_data and rsp_err pass straight from mem_rsp_*. Values are don't-care when rsp_valid=0.
// - Latency:
//   - Accept in cycle N; mem_req_valid in N+1.
//   - Earliest response in N+2.
//   - Next accept is no earlier than the cycle after the response (one bubble).
// - Requesters hold valid and payload until ready. No requester can starve: with both valid,
//   grants strictly alternate.
// - mem_rsp_valid in IDLE or ISSUE:
//   - Ignored; no rsp_valid is raised.
//   - proto_err sets and stays set until reset.
// - mem_rsp_err=1 is forwarded as-is, and the transaction completes normally.
// - Reset asserted mid-transaction:
//   - Returns immediately to IDLE; the in-flight transaction is discarded.
//   - The memory is reset by the same rst_n.
// TESTING
// - IF only, addr=0x100, mem ready at once, rsp data=0xDEADBEEF after 2 cycles
//   -> if_rsp_valid pulse with 0xDEADBEEF; ls_rsp_valid stays 0.
// - IF and LS both valid out of reset -> LS granted first. Then, with both still valid,
//   grants alternate: IF, LS, IF.
// - LS store, addr=0x200, wdata=0x12345678, wstrb=0b0011, mem_req_ready low for 3 cycles
//   -> payload held stable for all 3 cycles; exactly one handshake; state moves to WAIT.
// - LS load with mem_rsp_err=1 -> ls_rsp_valid=1 and ls_rsp_err=1 for one cycle; next state IDLE.
// - mem_rsp_valid pulsed in IDLE -> no rsp_valid raised; proto_err=1 until rst_n is asserted.
// - rst_n asserted during WAIT, then mem_rsp_valid after release -> state IDLE, no rsp routed,
//   proto_err=1.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing the core memory port between fetch and load/store.
// One transaction in flight; responses are routed back to the owner with zero latency.
module core_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_valid,
  input  logic [AW-1:0] if_req_addr,
  output logic          if_req_ready,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  output logic          if_rsp_err,
  input  logic          ls_req_valid,
  input  logic [AW-1:0] ls_req_addr,
  input  logic          ls_req_wen,
  input  logic [DW-1:0] ls_req_wdata,
  input  logic [DW/8-1:0] ls_req_wstrb,
  output logic          ls_req_ready,
  output logic          ls_rsp_valid,
  output logic [DW-1:0] ls_rsp_data,
  output logic          ls_rsp_err,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  output logic          mem_req_wen,
  output logic [DW-1:0] mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data,
  input  logic          mem_rsp_err,
  output logic          proto_err
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  // Requester identity: 0 = IF, 1 = LS
  logic last_q, last_d;
  logic owner_q, owner_d;

  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          perr_q, perr_d;

  logic win_if;
  logic win_ls;
  logic idle;
  logic accept;
  logic in_wait;

  // On a tie the requester that did not win last time goes next
  assign win_if = if_req_valid &&
                  (!ls_req_valid || last_q);
  assign win_ls = ls_req_valid &&
                  (!if_req_valid || !last_q);

  assign idle    = rst_n && (state_q == S_IDLE);
  assign in_wait = (state_q == S_WAIT);

  assign if_req_ready = idle && win_if;
  assign ls_req_ready = idle && win_ls;
  assign accept = if_req_ready || ls_req_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    perr_d  = perr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          last_d  = ls_req_ready;
          owner_d = ls_req_ready;
          if (ls_req_ready) begin
            addr_d  = ls_req_addr;
            wen_d   = ls_req_wen;
            wdata_d = ls_req_wdata;
            wstrb_d = ls_req_wstrb;
          end else begin
            addr_d  = if_req_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (mem_rsp_valid && !in_wait) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      perr_q  <= perr_d;
    end
  end

  assign mem_req_valid = (state_q == S_ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

  assign if_rsp_valid = mem_rsp_valid && in_wait && !owner_q;
  assign ls_rsp_valid = mem_rsp_valid && in_wait && owner_q;
  assign if_rsp_data  = mem_rsp_data;
  assign if_rsp_err   = mem_rsp_err;
  assign ls_rsp_data  = mem_rsp_data;
  assign ls_rsp_err   = mem_rsp_err;

  assign proto_err = perr_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of requesters and memory.
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        ls_req_valid = 1'b0;
  logic [31:0] ls_req_addr = '0;
  logic        ls_req_wen = 1'b0;
  logic [31:0] ls_req_wdata = '0;
  logic [3:0]  ls_req_wstrb = '0;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        ls_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        proto_err;

  core_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr),
    .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata),
    .ls_req_wstrb(ls_req_wstrb), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .ls_rsp_err(ls_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ls;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  int total = 0;
  int bad = 0;

  txn_t ifq[$];
  txn_t lsq[$];
  bit   grants[$];
  txn_t cur;
  bit   busy = 0;
  bit   hs = 0;
  bit   last_ls = 0;
  bit   exp_perr = 0;
  bit   stray = 0;
  bit   rnd = 0;
  int   rdy_wait = 0;
  int   rsp_wait = 0;
  int   rdy_lat = 0;
  int   rsp_gap = 1;
  logic [31:0] rdata = '0;
  logic rerr = 1'b0;
  int   n_if_rsp = 0;
  int   n_ls_rsp = 0;
  int   n_hs = 0;
  int   issue_cycles = 0;

  task automatic chk1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(string tag, logic [3:0] obs, logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_if(logic [31:0] a);
    txn_t t;
    t.ls = 0; t.addr = a; t.wen = 0;
    t.wdata = '0; t.wstrb = '0;
    ifq.push_back(t);
  endtask

  task automatic push_ls(logic [31:0] a, bit w,
                         logic [31:0] d, logic [3:0] s);
    txn_t t;
    t.ls = 1; t.addr = a; t.wen = w;
    t.wdata = d; t.wstrb = s;
    lsq.push_back(t);
  endtask

  task automatic cycle();
    bit eifr, elsr, rsp, eifv, elsv, owned;
    @(negedge clk);
    if_req_valid = (ifq.size() > 0);
    if (ifq.size() > 0) if_req_addr = ifq[0].addr;
    ls_req_valid = (lsq.size() > 0);
    if (lsq.size() > 0) begin
      ls_req_addr  = lsq[0].addr;
      ls_req_wen   = lsq[0].wen;
      ls_req_wdata = lsq[0].wdata;
      ls_req_wstrb = lsq[0].wstrb;
    end
    mem_req_ready = busy && !hs && (rdy_wait == 0);
    owned = busy && hs && (rsp_wait == 0);
    rsp = owned || (stray && !(busy && hs));
    stray = 0;
    if (rsp && rnd) begin
      rdata = $urandom;
      rerr = ($urandom_range(0, 3) == 0);
    end
    mem_rsp_valid = rsp;
    mem_rsp_data = rdata;
    mem_rsp_err = rerr;
    #1;
    eifr = !busy && ifq.size() > 0 && (lsq.size() == 0 || last_ls);
    elsr = !busy && lsq.size() > 0 && (ifq.size() == 0 || !last_ls);
    eifv = owned && !cur.ls;
    elsv = owned && cur.ls;
    chk1("if_req_ready", if_req_ready, eifr);
    chk1("ls_req_ready", ls_req_ready, elsr);
    chk1("mem_req_valid", mem_req_valid, busy && !hs);
    if (busy && !hs) begin
      issue_cycles++;
      chk32("mem_req_addr", mem_req_addr, cur.addr);
      chk1("mem_req_wen", mem_req_wen, cur.wen);
      chk32("mem_req_wdata", mem_req_wdata, cur.wdata);
      chk4("mem_req_wstrb", mem_req_wstrb, cur.wstrb);
    end
    chk1("if_rsp_valid", if_rsp_valid, eifv);
    chk1("ls_rsp_valid", ls_rsp_valid, elsv);
    if (eifv) begin
      n_if_rsp++;
      chk32("if_rsp_data", if_rsp_data, rdata);
      chk1("if_rsp_err", if_rsp_err, rerr);
    end
    if (elsv) begin
      n_ls_rsp++;
      chk32("ls_rsp_data", ls_rsp_data, rdata);
      chk1("ls_rsp_err", ls_rsp_err, rerr);
    end
    chk1("proto_err", proto_err, exp_perr);
    if (rsp && !(busy && hs)) exp_perr = 1;
    if (busy && hs) begin
      if (owned) busy = 0;
      else rsp_wait--;
    end else if (busy) begin
      if (mem_req_ready) begin
        hs = 1;
        n_hs++;
        rsp_wait = rnd ? $urandom_range(0, 2) : rsp_gap - 1;
      end else begin
        rdy_wait--;
      end
    end
    if (eifr || elsr) begin
      if (elsr) cur = lsq.pop_front();
      else cur = ifq.pop_front();
      last_ls = elsr;
      grants.push_back(elsr);
      busy = 1;
      hs = 0;
      rdy_wait = rnd ? $urandom_range(0, 2) : rdy_lat;
    end
  endtask

  task automatic drain(int max);
    int k;
    bit done;
    k = 0;
    while ((busy || ifq.size() > 0 || lsq.size() > 0) && k < max) begin
      cycle();
      k++;
    end
    done = !(busy || ifq.size() > 0 || lsq.size() > 0);
    chk1("drain", done, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    #1;
    chk1("rst if_req_ready", if_req_ready, 1'b0);
    chk1("rst ls_req_ready", ls_req_ready, 1'b0);
    chk1("rst if_rsp_valid", if_rsp_valid, 1'b0);
    chk1("rst ls_rsp_valid", ls_rsp_valid, 1'b0);
    chk1("rst mem_req_valid", mem_req_valid, 1'b0);
    chk32("rst mem_req_addr", mem_req_addr, 32'h0);
    chk1("rst mem_req_wen", mem_req_wen, 1'b0);
    chk32("rst mem_req_wdata", mem_req_wdata, 32'h0);
    chk4("rst mem_req_wstrb", mem_req_wstrb, 4'h0);
    chk1("rst proto_err", proto_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    busy = 0; hs = 0; last_ls = 0; exp_perr = 0;
    ifq.delete(); lsq.delete(); grants.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    do_reset();

    // IF-only read, memory ready at once, data two cycles after accept
    rdata = 32'hDEADBEEF; rerr = 1'b0; rdy_lat = 0; rsp_gap = 1;
    n_if_rsp = 0; n_ls_rsp = 0;
    push_if(32'h100);
    drain(20);
    chk32("if only if_rsp count", 32'(n_if_rsp), 32'd1);
    chk32("if only ls_rsp count", 32'(n_ls_rsp), 32'd0);

    // Both valid out of reset: LS first, then strict alternation
    do_reset();
    rdata = 32'hCAFE0001;
    for (int i = 0; i < 4; i++) begin
      push_if(32'h1000 + 32'(i * 4));
      push_ls(32'h2000 + 32'(i * 4), 1'b0, 32'h0, 4'h0);
    end
    drain(100);
    for (int i = 0; i < 6; i++)
      chk1($sformatf("grant%0d", i), grants[i], (i % 2) == 0);

    // Store with memory stalling the handshake for three cycles
    rdy_lat = 3; n_hs = 0; issue_cycles = 0;
    push_ls(32'h200, 1'b1, 32'h12345678, 4'b0011);
    drain(20);
    chk32("stall handshakes", 32'(n_hs), 32'd1);
    chk32("stall issue cycles", 32'(issue_cycles), 32'd4);

    // Load returning an access fault
    rdy_lat = 0; rerr = 1'b1; rdata = 32'h0BADF00D; n_ls_rsp = 0;
    push_ls(32'h300, 1'b0, 32'h0, 4'h0);
    drain(20);
    chk32("err ls_rsp count", 32'(n_ls_rsp), 32'd1);
    rerr = 1'b0;
    cycle();

    // Stray response in IDLE sets the sticky error
    stray = 1;
    cycle();
    push_if(32'h400);
    drain(20);
    repeat (3) cycle();
    chk1("proto_err sticky", proto_err, 1'b1);

    // Reset while waiting for a response, then a late response
    do_reset();
    rsp_gap = 4;
    push_ls(32'h500, 1'b0, 32'h0, 4'h0);
    k = 0;
    while (!(busy && hs) && k < 10) begin
      cycle();
      k++;
    end
    chk1("reached wait", busy && hs, 1'b1);
    do_reset();
    rsp_gap = 1;
    n_if_rsp = 0; n_ls_rsp = 0;
    stray = 1;
    cycle();
    cycle();
    chk1("late rsp proto_err", proto_err, 1'b1);
    chk32("late rsp routed", 32'(n_if_rsp + n_ls_rsp), 32'd0);

    // Random traffic
    do_reset();
    rnd = 1;
    for (int i = 0; i < 800; i++) begin
      if (ifq.size() == 0 && $urandom_range(0, 2) != 0)
        push_if($urandom & 32'hFFFF_FFFC);
      if (lsq.size() == 0 && $urandom_range(0, 2) != 0)
        push_ls($urandom, 1'($urandom_range(0, 1)),
                $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 60) == 0) stray = 1;
      cycle();
    end
    drain(50);
    rnd = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
